// File: rtl/logic_reg_arbiter.sv
//==============================================================================
// Module      : logic_reg_arbiter
// Description : Round-robin arbiter that writes the winning requester's data
//               into a shared register, then holds it before re-arbitrating.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module logic_reg_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         my_data,
    output logic                      en,
    output logic                      busy,
    output logic                      done
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [PTR_W-1:0] c_last_rst = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [PTR_W-1:0]    r_last;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_data;

    state_t              w_state_nxt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    logic [PTR_W-1:0]    w_last_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   w_data_nxt;

    logic [PTR_W-1:0]    w_scan;
    logic [PTR_W-1:0]    w_win;
    logic                w_found;
    logic [NUM_REQ-1:0]  w_onehot;
    logic [DATA_W-1:0]   w_sel;

    // Scan starts just after the previous winner and wraps NUM_REQ-1 -> 0.
    always_comb begin
        w_scan  = r_last;
        w_win   = r_last;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = (w_scan == c_last_rst) ? '0 : w_scan + PTR_W'(1);
            if (!w_found && req[w_scan]) begin
                w_found = 1'b1;
                w_win   = w_scan;
            end
        end
        w_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
    end

    // In GRANT, r_last still names the winner, so it selects the data slice.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_last == PTR_W'(i)) begin
                w_sel = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = '0;
                if (w_found) begin
                    w_gnt_nxt   = w_onehot;
                    w_last_nxt  = w_win;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                w_data_nxt  = w_sel;
                w_gnt_nxt   = '0;
                w_cnt_nxt   = c_cnt_load;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_last  <= c_last_rst;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign my_data = r_data;
    assign en      = r_data[0];
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_HOLD) && (r_cnt == '0);

endmodule

`default_nettype wire
